fix_palette_arbiter: RTL and testbench

- Shares the single 16-entry fix palette lookup among NUM_REQ sprite-layer requesters (player, enemy, bullet, HUD).
- Each cycle it grants one requester using round-robin with optional burst lock.
- It drives the palette index for the granted requester and registers the returned 12-bit colour.
- The colour is tagged with the requester id and a transparency flag for the downstream pixel compositor.

---
 rtl/fix_palette_arbiter.sv | 127 ++++++++++++
 tb/tb_fix_palette_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fix_palette_arbiter.sv
// Round-robin arbiter with burst lock that shares one 16-entry fix palette among sprite layers.
// The looked-up colour is registered with its requester id and a colour-key transparency flag.
module fix_palette_arbiter #(
  parameter int          NUM_REQ         = 4,
  parameter int          IDX_W           = 4,
  parameter int unsigned TRANSPARENT_IDX = 0,
  localparam int         ID_W            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     blank,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [NUM_REQ*IDX_W-1:0] index_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic [IDX_W-1:0]         pal_index,
  input  logic [3:0]               pal_red,
  input  logic [3:0]               pal_green,
  input  logic [3:0]               pal_blue,
  output logic                     rgb_valid,
  output logic [11:0]              rgb_out,
  output logic [ID_W-1:0]          rgb_id,
  output logic                     rgb_transparent
);

  typedef enum logic {ARB, BURST} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   locked_id_q, locked_id_d;
  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_id;

  logic              rgb_valid_q;
  logic [11:0]       rgb_out_q;
  logic [ID_W-1:0]   rgb_id_q;
  logic              rgb_transparent_q;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
    if (int'(id) >= NUM_REQ - 1) return '0;
    return id + ID_W'(1);
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      locked_id_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      locked_id_q <= locked_id_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    locked_id_d = locked_id_q;
    if (blank) begin
      state_d = ARB;
    end else if (state_q == BURST) begin
      if (!(req[locked_id_q] && lock[locked_id_q])) begin
        state_d  = ARB;
        rr_ptr_d = wrap_inc(locked_id_q);
      end
    end else if (gnt_vld) begin
      rr_ptr_d = wrap_inc(gnt_id);
      if (lock[gnt_id]) begin
        state_d     = BURST;
        locked_id_d = gnt_id;
      end
    end
  end

  // Walk offsets from the highest down so the requester closest to rr_ptr is the one left standing.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    if (Reset_n && !blank) begin
      if (state_q == BURST) begin
        if (req[locked_id_q]) begin
          gnt_vld = 1'b1;
          gnt_id  = locked_id_q;
        end
      end else begin
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
          if (req[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
            gnt_vld = 1'b1;
            gnt_id  = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
          end
        end
      end
    end
  end

  always_comb begin
    grant     = '0;
    pal_index = '0;
    if (gnt_vld) begin
      grant[gnt_id] = 1'b1;
      pal_index     = index_in[gnt_id*IDX_W +: IDX_W];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_valid_q       <= 1'b0;
      rgb_out_q         <= '0;
      rgb_id_q          <= '0;
      rgb_transparent_q <= 1'b0;
    end else begin
      rgb_valid_q <= gnt_vld;
      if (gnt_vld) begin
        rgb_out_q         <= {pal_red, pal_green, pal_blue};
        rgb_id_q          <= gnt_id;
        rgb_transparent_q <= (pal_index == IDX_W'(TRANSPARENT_IDX));
      end
    end
  end

  assign rgb_valid       = rgb_valid_q;
  assign rgb_out         = rgb_out_q;
  assign rgb_id          = rgb_id_q;
  assign rgb_transparent = rgb_transparent_q;

endmodule

// File: tb/tb_fix_palette_arbiter.sv
// Directed bench for fix_palette_arbiter: the driver pushes expected results into a scoreboard,
// and a monitor compares grants every cycle and pops/compares results whenever rgb_valid is high.
module tb_fix_palette_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        blank;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [15:0] index_in;
  logic [3:0]  grant;
  logic [3:0]  pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic        rgb_valid;
  logic [11:0] rgb_out;
  logic [1:0]  rgb_id;
  logic        rgb_transparent;

  typedef struct packed {
    logic [1:0]  id;
    logic [11:0] rgb;
    logic        tr;
  } exp_t;

  exp_t        sb[$];
  exp_t        got_e;
  logic [3:0]  exp_grant;
  logic [3:0]  exp_pidx;
  logic        exp_vld;
  logic        chk_en;
  logic        chk_rst;
  logic        done;
  logic        prev_g;
  int          n_chk = 0;
  int          n_fail = 0;
  event        chk_ev;

  fix_palette_arbiter #(.NUM_REQ(4), .IDX_W(4), .TRANSPARENT_IDX(0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .blank(blank), .req(req), .lock(lock),
    .index_in(index_in), .grant(grant), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .rgb_valid(rgb_valid), .rgb_out(rgb_out), .rgb_id(rgb_id),
    .rgb_transparent(rgb_transparent)
  );

  always #5 Clk = ~Clk;

  function automatic logic [11:0] pal_lut(input logic [3:0] i);
    case (i)
      4'd0:    return 12'hA4A;
      4'd2:    return 12'hDDD;
      4'd3:    return 12'hEA1;
      4'd15:   return 12'hC82;
      default: return {i, ~i, i ^ 4'h5};
    endcase
  endfunction

  assign {pal_red, pal_green, pal_blue} = pal_lut(pal_index);

  function automatic logic [1:0] oh2id(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k < 4; k++) if (oh[k]) r = 2'(k);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // One clock cycle of stimulus; called just after a rising edge.
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [15:0] idx,
                      input logic b, input logic [3:0] eg, input logic [3:0] eidx,
                      input logic [11:0] ergb);
    exp_t e2;
    req       = r;
    lock      = l;
    index_in  = idx;
    blank     = b;
    exp_grant = eg;
    exp_pidx  = (eg != 4'd0) ? eidx : 4'd0;
    exp_vld   = prev_g;
    @(posedge Clk);
    if (eg != 4'd0) begin
      e2.id  = oh2id(eg);
      e2.rgb = ergb;
      e2.tr  = (eidx == 4'd0);
      sb.push_back(e2);
    end
    prev_g = (eg != 4'd0);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge Clk or chk_ev);
      if (done) break;
      if (chk_en) begin
        chk("grant", 32'(grant), 32'(exp_grant));
        chk("pal_index", 32'(pal_index), 32'(exp_pidx));
        chk("rgb_valid", 32'(rgb_valid), 32'(exp_vld));
        if (chk_rst) begin
          chk("rst_rgb_out", 32'(rgb_out), 32'd0);
          chk("rst_rgb_id", 32'(rgb_id), 32'd0);
          chk("rst_rgb_transparent", 32'(rgb_transparent), 32'd0);
        end else if (rgb_valid === 1'b1) begin
          chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            got_e = sb.pop_front();
            chk("rgb_out", 32'(rgb_out), 32'(got_e.rgb));
            chk("rgb_id", 32'(rgb_id), 32'(got_e.id));
            chk("rgb_transparent", 32'(rgb_transparent), 32'(got_e.tr));
          end
        end
      end
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n   = 1'b0;
    blank     = 1'b0;
    req       = 4'b1111;
    lock      = 4'b0000;
    index_in  = 16'h3333;
    exp_grant = 4'd0;
    exp_pidx  = 4'd0;
    exp_vld   = 1'b0;
    chk_rst   = 1'b1;
    chk_en    = 1'b1;
    prev_g    = 1'b0;
    done      = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    chk_rst = 1'b0;

    // Round robin with all requesters active
    for (int c = 0; c < 8; c++)
      step(4'b1111, 4'b0000, 16'h3333, 1'b0, 4'(1 << (c % 4)), 4'h3, 12'hEA1);

    // Burst lock on requester 0, then handover to requester 2
    repeat (5) step(4'b0101, 4'b0001, 16'h0203, 1'b0, 4'b0001, 4'h3, 12'hEA1);
    step(4'b0101, 4'b0000, 16'h0203, 1'b0, 4'b0001, 4'h3, 12'hEA1);
    step(4'b0101, 4'b0000, 16'h0203, 1'b0, 4'b0100, 4'h2, 12'hDDD);

    // Palette lookups and transparency on requester 1
    step(4'b0010, 4'b0000, 16'h0000, 1'b0, 4'b0010, 4'h0, 12'hA4A);
    step(4'b0010, 4'b0000, 16'h0020, 1'b0, 4'b0010, 4'h2, 12'hDDD);
    step(4'b0010, 4'b0000, 16'h00F0, 1'b0, 4'b0010, 4'hF, 12'hC82);

    // Blanking keeps the pointer
    repeat (3) step(4'b1111, 4'b0000, 16'h3333, 1'b1, 4'b0000, 4'h0, 12'h000);
    step(4'b1111, 4'b0000, 16'h3333, 1'b0, 4'b0100, 4'h3, 12'hEA1);

    // Idle cycle, then lock on non-requesting lines is ignored
    step(4'b0000, 4'b0000, 16'h3333, 1'b0, 4'b0000, 4'h0, 12'h000);
    step(4'b0001, 4'b1110, 16'h3333, 1'b0, 4'b0001, 4'h3, 12'hEA1);
    step(4'b0011, 4'b0000, 16'h3333, 1'b0, 4'b0010, 4'h3, 12'hEA1);

    // Burst on requester 2 cut short by an asynchronous reset
    step(4'b0100, 4'b0100, 16'h0300, 1'b0, 4'b0100, 4'h3, 12'hEA1);
    step(4'b0100, 4'b0100, 16'h0300, 1'b0, 4'b0100, 4'h3, 12'hEA1);
    exp_grant = 4'b0100;
    exp_pidx  = 4'h3;
    exp_vld   = 1'b1;
    @(negedge Clk);
    #2;
    Reset_n   = 1'b0;
    chk_rst   = 1'b1;
    exp_grant = 4'd0;
    exp_pidx  = 4'd0;
    exp_vld   = 1'b0;
    #1;
    -> chk_ev;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    chk_rst = 1'b0;
    prev_g  = 1'b0;
    req     = 4'b1111;
    lock    = 4'b0000;
    step(4'b1111, 4'b0000, 16'h3333, 1'b0, 4'b0001, 4'h3, 12'hEA1);
    step(4'b1111, 4'b0000, 16'h3333, 1'b0, 4'b0010, 4'h3, 12'hEA1);

    step(4'b0000, 4'b0000, 16'h3333, 1'b0, 4'b0000, 4'h0, 12'h000);
    step(4'b0000, 4'b0000, 16'h3333, 1'b0, 4'b0000, 4'h0, 12'h000);
    done = 1'b1;
  end

endmodule
